// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge: MMIO front end with TX and RX byte FIFOs between the bus and the UART engines.
// Optional feature: define UART_FIFO_IRQ_EN to add the registered irq_o output.
module uart_fifo_bridge #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       cs_i,
  input  logic       data_reg_i,
  input  logic       wren_i,
  input  logic [7:0] di_i,
  output logic [7:0] do_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i
`ifdef UART_FIFO_IRQ_EN
  ,
  output logic       irq_o
`endif
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;

  localparam cnt_t CntFull = cnt_t'(Depth);
  localparam cnt_t CntOne  = cnt_t'(1);
  localparam ptr_t PtrOne  = ptr_t'(1);

  logic [7:0] tx_mem [Depth];
  logic [7:0] rx_mem [Depth];

  ptr_t tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  ptr_t rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  cnt_t tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic       cs_q;
  logic       ovf_q, ovf_d;
  logic [7:0] do_q, do_d;
  logic       irq_q, irq_d;

  logic access, rd_data, rd_stat, wr_data;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop, ovf_set;
  logic [7:0] status;

  // Decode the access edge and the push/pop strobes of both FIFOs.
  always_comb begin
    access   = cs_i & ~cs_q;
    rd_data  = access & data_reg_i & ~wren_i;
    rd_stat  = access & ~data_reg_i & ~wren_i;
    wr_data  = access & data_reg_i & wren_i;
    tx_full  = (tx_cnt_q == CntFull);
    tx_empty = (tx_cnt_q == '0);
    rx_full  = (rx_cnt_q == CntFull);
    rx_empty = (rx_cnt_q == '0);
    tx_pop   = ~tx_empty & tx_ready_i;
    // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
    tx_push  = wr_data & (~tx_full | tx_pop);
    rx_pop   = rd_data & ~rx_empty;
    rx_push  = rx_valid_i & (~rx_full | rx_pop);
    ovf_set  = rx_valid_i & rx_full & ~rx_pop;
    status   = {4'b0000, tx_empty, ovf_q, ~tx_full, ~rx_empty};
  end

  // Next-state for pointers, counts, sticky overflow, read data and irq.
  always_comb begin
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    tx_cnt_d    = tx_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    ovf_d       = ovf_q;
    do_d        = do_q;

    if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + PtrOne;
    if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + PtrOne;
    if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + CntOne;
    if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - CntOne;

    if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + PtrOne;
    if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + PtrOne;
    if (rx_push && !rx_pop) rx_cnt_d = rx_cnt_q + CntOne;
    if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - CntOne;

    // Status read clears overflow, but a simultaneous new overflow wins.
    if (rd_stat) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;

    // Read data is captured on the access edge, held while selected, zero otherwise.
    if (!cs_i) begin
      do_d = 8'h00;
    end else if (access) begin
      if (rd_data)      do_d = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr_q];
      else if (rd_stat) do_d = status;
      else              do_d = 8'h00;
    end

    irq_d = (rx_cnt_d != '0) | ovf_d;
  end

  // Control state with asynchronous clear.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
      rx_cnt_q    <= '0;
      cs_q        <= 1'b0;
      ovf_q       <= 1'b0;
      do_q        <= 8'h00;
      irq_q       <= 1'b0;
    end else begin
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      cs_q        <= cs_i;
      ovf_q       <= ovf_d;
      do_q        <= do_d;
      irq_q       <= irq_d;
    end
  end

  // FIFO storage; not reset, only the pointers and counts define its contents.
  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wr_ptr_q] <= di_i;
    if (rx_push) rx_mem[rx_wr_ptr_q] <= rx_data_i;
  end

  // Outputs come straight from registered state.
  always_comb begin
    do_o       = do_q;
    tx_valid_o = ~tx_empty;
    tx_data_o  = tx_mem[tx_rd_ptr_q];
  end

`ifdef UART_FIFO_IRQ_EN
  assign irq_o = irq_q;
`else
  logic unused_irq;
  assign unused_irq = irq_q;
`endif

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Testbench for uart_fifo_bridge: directed vector table, corner sequences and
// randomized traffic checked against a queue-based model. Honours UART_FIFO_IRQ_EN.
module tb_uart_fifo_bridge;

  logic       clk = 1'b0;
  logic       reset;
  logic       cs, data_reg, wren, tx_ready, rx_valid;
  logic [7:0] di, rx_data, dout, tx_data;
  logic       tx_valid, irq;

  always #5 clk = ~clk;

  uart_fifo_bridge #(.DEPTH_LOG2(4)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .cs_i       (cs),
    .data_reg_i (data_reg),
    .wren_i     (wren),
    .di_i       (di),
    .do_o       (dout),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .tx_ready_i (tx_ready),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid)
`ifdef UART_FIFO_IRQ_EN
    ,
    .irq_o      (irq)
`endif
  );

`ifndef UART_FIFO_IRQ_EN
  assign irq = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model: byte queues, sticky overflow flag, expected read data.
  logic [7:0] m_tx[$];
  logic [7:0] m_rx[$];
  bit         m_ovf = 1'b0;
  bit         m_csp = 1'b0;
  logic [7:0] m_do  = 8'h00;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h, expected %02h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit         acc;
    logic [7:0] st;
    acc = cs && !m_csp;
    st  = {4'b0000, 1'(m_tx.size() == 0), m_ovf, 1'(m_tx.size() < 16), 1'(m_rx.size() > 0)};
    if (!cs) m_do = 8'h00;
    else if (acc) begin
      if (wren)          m_do = 8'h00;
      else if (data_reg) m_do = (m_rx.size() > 0) ? m_rx[0] : 8'h00;
      else               m_do = st;
    end
    if (m_tx.size() > 0 && tx_ready) void'(m_tx.pop_front());
    if (acc && data_reg && wren && m_tx.size() < 16) m_tx.push_back(di);
    if (acc && data_reg && !wren && m_rx.size() > 0) void'(m_rx.pop_front());
    if (acc && !data_reg && !wren) m_ovf = 1'b0;
    if (rx_valid) begin
      if (m_rx.size() < 16) m_rx.push_back(rx_data);
      else                  m_ovf = 1'b1;
    end
    m_csp = cs;
  endtask

  task automatic check_model();
    chk("do", dout, m_do);
    chk("tx_valid", 8'(tx_valid), 8'(m_tx.size() > 0));
    if (m_tx.size() > 0) chk("tx_data", tx_data, m_tx[0]);
`ifdef UART_FIFO_IRQ_EN
    chk("irq", 8'(irq), 8'(m_rx.size() > 0 || m_ovf));
`endif
  endtask

  // One clock: apply inputs, advance the model, compare #1 after the edge.
  task automatic drive(input bit c, input bit d, input bit w, input logic [7:0] dd,
                       input bit tr, input logic [7:0] rd, input bit rv);
    cs = c; data_reg = d; wren = w; di = dd; tx_ready = tr; rx_data = rd; rx_valid = rv;
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  typedef struct {
    bit         cs, dr, wr;
    logic [7:0] di;
    bit         txr;
    logic [7:0] rxd;
    bit         rxv;
    logic [7:0] e_do;
    bit         e_txv;
    logic [7:0] e_txd;
  } vec_t;

  vec_t tbl[23];

  initial begin
    // cs dr wr di txr rxd rxv | do txv txd
    tbl[0]  = '{1, 1, 1, 8'h41, 0, 8'h00, 0, 8'h00, 1, 8'h41};
    tbl[1]  = '{0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1, 8'h41};
    tbl[2]  = '{1, 1, 1, 8'h42, 0, 8'h00, 0, 8'h00, 1, 8'h41};
    tbl[3]  = '{0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1, 8'h41};
    tbl[4]  = '{1, 1, 1, 8'h43, 0, 8'h00, 0, 8'h00, 1, 8'h41};
    tbl[5]  = '{0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1, 8'h41};
    tbl[6]  = '{0, 0, 0, 8'h00, 1, 8'h00, 0, 8'h00, 1, 8'h42};
    tbl[7]  = '{0, 0, 0, 8'h00, 1, 8'h00, 0, 8'h00, 1, 8'h43};
    tbl[8]  = '{0, 0, 0, 8'h00, 1, 8'h00, 0, 8'h00, 0, 8'h00};
    tbl[9]  = '{1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h0A, 0, 8'h00};
    tbl[10] = '{0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h00};
    tbl[11] = '{0, 0, 0, 8'h00, 0, 8'h55, 1, 8'h00, 0, 8'h00};
    tbl[12] = '{0, 0, 0, 8'h00, 0, 8'hAA, 1, 8'h00, 0, 8'h00};
    tbl[13] = '{1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h0B, 0, 8'h00};
    tbl[14] = '{0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h00};
    tbl[15] = '{1, 1, 0, 8'h00, 0, 8'h00, 0, 8'h55, 0, 8'h00};
    tbl[16] = '{0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h00};
    tbl[17] = '{1, 1, 0, 8'h00, 0, 8'h00, 0, 8'hAA, 0, 8'h00};
    tbl[18] = '{0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h00};
    tbl[19] = '{1, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h00};
    tbl[20] = '{0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h00};
    tbl[21] = '{1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h0A, 0, 8'h00};
    tbl[22] = '{0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h00};

    reset = 1'b1;
    cs = 0; data_reg = 0; wren = 0; di = 0; tx_ready = 0; rx_data = 0; rx_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_do", dout, 8'h00);
    chk("reset_tx_valid", 8'(tx_valid), 8'h00);
    chk("reset_irq", 8'(irq), 8'h00);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed table: TX write/drain, RX push/pop, status values.
    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].cs, tbl[i].dr, tbl[i].wr, tbl[i].di, tbl[i].txr, tbl[i].rxd, tbl[i].rxv);
      chk($sformatf("tbl%0d_do", i), dout, tbl[i].e_do);
      chk($sformatf("tbl%0d_tx_valid", i), 8'(tx_valid), 8'(tbl[i].e_txv));
      if (tbl[i].e_txv) chk($sformatf("tbl%0d_tx_data", i), tx_data, tbl[i].e_txd);
    end

    // RX overflow: 17 strobes into a 16-deep FIFO.
    for (int i = 0; i < 17; i++) drive(0, 0, 0, 8'h00, 0, 8'(8'h10 + i), 1);
    drive(1, 0, 0, 8'h00, 0, 8'h00, 0);
    chk("ovf_set", 8'(dout[2]), 8'h01);
    idle();
    drive(1, 0, 0, 8'h00, 0, 8'h00, 0);
    chk("ovf_clr", 8'(dout[2]), 8'h00);
    idle();

    // Full RX FIFO: pop and push in the same cycle, no overflow.
    drive(1, 1, 0, 8'h00, 0, 8'hEE, 1);
    chk("coll_do", dout, 8'h10);
    idle();
    drive(1, 0, 0, 8'h00, 0, 8'h00, 0);
    chk("coll_status", dout & 8'h05, 8'h01);
    idle();
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 0, 8'h00, 0, 8'h00, 0);
      chk($sformatf("drain%0d", i), dout, (i < 15) ? 8'(8'h11 + i) : 8'hEE);
      idle();
    end
    drive(1, 1, 0, 8'h00, 0, 8'h00, 0);
    chk("drain_empty", dout, 8'h00);
    idle();

    // cs held three cycles on a DATA read: one pop, stable data.
    drive(0, 0, 0, 8'h00, 0, 8'h5A, 1);
    drive(0, 0, 0, 8'h00, 0, 8'h6B, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 8'h00, 0, 8'h00, 0);
      chk($sformatf("hold%0d", i), dout, 8'h5A);
    end
    idle();
    chk("hold_release", dout, 8'h00);
    drive(1, 1, 0, 8'h00, 0, 8'h00, 0);
    chk("hold_next", dout, 8'h6B);
    idle();

`ifdef UART_FIFO_IRQ_EN
    drive(0, 0, 0, 8'h00, 0, 8'h77, 1);
    chk("irq_rise", 8'(irq), 8'h01);
    idle();
    drive(1, 1, 0, 8'h00, 0, 8'h00, 0);
    chk("irq_fall", 8'(irq), 8'h00);
    idle();
`endif

    // Randomized traffic in phases biased towards filling or draining.
    for (int p = 0; p < 4; p++) begin
      int rx_pct, tx_pct;
      rx_pct = (p == 0) ? 30 : (p == 1) ? 80 : (p == 2) ? 5 : 50;
      tx_pct = (p == 0) ? 50 : (p == 1) ? 5 : (p == 2) ? 80 : 50;
      for (int n = 0; n < 1000; n++) begin
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              8'($urandom), 1'($urandom_range(0, 99) < tx_pct), 8'($urandom),
              1'($urandom_range(0, 99) < rx_pct));
      end
    end

    // Asynchronous reset in the middle of traffic.
    drive(1, 1, 1, 8'hC3, 0, 8'h99, 1);
    idle();
    drive(1, 1, 0, 8'h00, 0, 8'h00, 0);
    #3;
    reset = 1'b1;
    #1;
    chk("mid_reset_tx_valid", 8'(tx_valid), 8'h00);
    chk("mid_reset_irq", 8'(irq), 8'h00);
    chk("mid_reset_do", dout, 8'h00);
    m_tx.delete();
    m_rx.delete();
    m_ovf = 1'b0;
    m_csp = 1'b0;
    m_do  = 8'h00;
    cs = 0; data_reg = 0; wren = 0; tx_ready = 0; rx_valid = 0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    drive(1, 0, 0, 8'h00, 0, 8'h00, 0);
    chk("post_reset_status", dout, 8'h0A);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
